// File: rtl/writeback_arbiter.sv
// Writeback arbiter: three result sources (ALU/load, MUL, FPU) share one register-file write port.
// Latency: a result accepted on edge E0 is written (reg_write_o=1) in the cycle after E1 when uncontended.
// Backpressure: each source has a one-entry holding buffer; sN_ready drops while that buffer waits for a grant.
// Optional feature: define WB_BYPASS_EN to drive the bypass outputs from the in-flight write.
module writeback_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        s0_valid,
    output logic        s0_ready,
    input  logic [4:0]  s0_rd,
    input  logic [31:0] s0_data,
    input  logic        s0_fp,
    input  logic        s1_valid,
    output logic        s1_ready,
    input  logic [4:0]  s1_rd,
    input  logic [31:0] s1_data,
    input  logic        s1_fp,
    input  logic        s2_valid,
    output logic        s2_ready,
    input  logic [4:0]  s2_rd,
    input  logic [31:0] s2_data,
    input  logic        s2_fp,
    output logic        reg_write_o,
    output logic [4:0]  write_reg,
    output logic [31:0] write_data,
    output logic        FPR_GPR_sel,
    output logic        busy,
    input  logic [4:0]  byp_rs1,
    input  logic [4:0]  byp_rs2,
    input  logic        byp_fp,
    output logic        byp_hit1,
    output logic        byp_hit2,
    output logic [31:0] byp_data
);

    // Per-source views of the input ports, indexed by source number.
    logic [2:0]  w_in_vld;
    logic [2:0]  w_in_fp;
    logic [4:0]  w_in_rd   [3];
    logic [31:0] w_in_data [3];

    assign w_in_vld     = {s2_valid, s1_valid, s0_valid};
    assign w_in_fp      = {s2_fp, s1_fp, s0_fp};
    assign w_in_rd[0]   = s0_rd;
    assign w_in_rd[1]   = s1_rd;
    assign w_in_rd[2]   = s2_rd;
    assign w_in_data[0] = s0_data;
    assign w_in_data[1] = s1_data;
    assign w_in_data[2] = s2_data;

    // Holding buffers and arbitration state.
    logic [2:0]  r_full;
    logic [2:0]  r_fp;
    logic [4:0]  r_rd   [3];
    logic [31:0] r_data [3];
    logic [1:0]  r_last_grant;

    // Registered write port.
    logic        r_we;
    logic [4:0]  r_wreg;
    logic [31:0] r_wdata;
    logic        r_wfp;

    logic [2:0]  w_grant;
    logic [1:0]  w_gidx;
    logic        w_any;
    logic [2:0]  w_ready;
    logic [2:0]  w_accept;
    logic [2:0]  w_discard;

    // Round-robin pick among full buffers, starting one past the last winner.
    always_comb begin
        w_any  = 1'b0;
        w_gidx = 2'd0;
        case (r_last_grant)
            2'd0: begin
                if (r_full[1])      begin w_any = 1'b1; w_gidx = 2'd1; end
                else if (r_full[2]) begin w_any = 1'b1; w_gidx = 2'd2; end
                else if (r_full[0]) begin w_any = 1'b1; w_gidx = 2'd0; end
            end
            2'd1: begin
                if (r_full[2])      begin w_any = 1'b1; w_gidx = 2'd2; end
                else if (r_full[0]) begin w_any = 1'b1; w_gidx = 2'd0; end
                else if (r_full[1]) begin w_any = 1'b1; w_gidx = 2'd1; end
            end
            default: begin
                if (r_full[0])      begin w_any = 1'b1; w_gidx = 2'd0; end
                else if (r_full[1]) begin w_any = 1'b1; w_gidx = 2'd1; end
                else if (r_full[2]) begin w_any = 1'b1; w_gidx = 2'd2; end
            end
        endcase
        w_grant = w_any ? (3'b001 << w_gidx) : 3'b000;
    end

    // A buffer can take a new result when empty or when it drains this cycle.
    assign w_ready   = (~r_full | w_grant) & {3{~rst}};
    assign w_accept  = w_in_vld & w_ready;
    assign w_discard = ~w_in_fp & {(w_in_rd[2] == 5'd0), (w_in_rd[1] == 5'd0), (w_in_rd[0] == 5'd0)};

    assign s0_ready = w_ready[0];
    assign s1_ready = w_ready[1];
    assign s2_ready = w_ready[2];

    // Holding buffers: capture on handshake (x0 GPR writes are swallowed), clear on grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_full <= 3'b000;
        end else begin
            for (int n = 0; n < 3; n++) begin
                if (w_accept[n]) begin
                    r_full[n] <= ~w_discard[n];
                    r_rd[n]   <= w_in_rd[n];
                    r_data[n] <= w_in_data[n];
                    r_fp[n]   <= w_in_fp[n];
                end else if (w_grant[n]) begin
                    r_full[n] <= 1'b0;
                end
            end
        end
    end

    // Remember the winner so the next search starts after it; port 0 wins first out of reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_grant <= 2'd2;
        end else if (w_any) begin
            r_last_grant <= w_gidx;
        end
    end

    // Write port: load the granted buffer, otherwise drop the strobe and hold the payload.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_we    <= 1'b0;
            r_wreg  <= 5'd0;
            r_wdata <= 32'd0;
            r_wfp   <= 1'b0;
        end else if (w_any) begin
            r_we    <= 1'b1;
            r_wreg  <= r_rd[w_gidx];
            r_wdata <= r_data[w_gidx];
            r_wfp   <= r_fp[w_gidx];
        end else begin
            r_we    <= 1'b0;
        end
    end

    assign reg_write_o = r_we;
    assign write_reg   = r_wreg;
    assign write_data  = r_wdata;
    assign FPR_GPR_sel = r_wfp;
    assign busy        = (|r_full) | r_we;

`ifdef WB_BYPASS_EN
    // Forward the write currently on the port to decode-stage operand reads.
    assign byp_hit1 = r_we & (r_wreg == byp_rs1) & (r_wfp == byp_fp);
    assign byp_hit2 = r_we & (r_wreg == byp_rs2) & (r_wfp == byp_fp);
    assign byp_data = r_wdata;
`else
    // Bypass disabled: outputs tied low, inputs intentionally unused.
    logic w_unused_byp;
    assign w_unused_byp = ^{byp_rs1, byp_rs2, byp_fp};
    assign byp_hit1     = 1'b0;
    assign byp_hit2     = 1'b0;
    assign byp_data     = 32'd0;
`endif

endmodule
